// File: rtl/emmc_pkg.sv
// Shared constants, state encoding and CRC7 step function for the eMMC CMD-line responder.
// Optional receive CRC checking is enabled by defining EMMC_RESP_CRC_CHECK_EN.
package emmc_pkg;

    localparam int          FRAME_LEN  = 48;
    localparam int          CRC_LEN    = 40;
    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [5:0]  CMD0_INDEX = 6'd0;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        CHECK,
        WAIT_NCR,
        TX
    } state_t;

    // One bit of the x^7+x^3+1 CRC, MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/emmc_crc7.sv
// Serial CRC7 accumulator with synchronous clear; clear wins over enable.
module emmc_crc7
    import emmc_pkg::*;
(
    input  logic       mclk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_reg;

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            crc_reg <= '0;
        end else if (clr) begin
            crc_reg <= '0;
        end else if (en) begin
            crc_reg <= crc7_step(crc_reg, din);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/emmc_cmd_responder.sv
// eMMC device-side CMD line: receives 48-bit commands and answers with an R1-style response.
// Define EMMC_RESP_CRC_CHECK_EN to reject commands whose received CRC7 is wrong.
module emmc_cmd_responder
    import emmc_pkg::*;
#(
    parameter int NCR = 2
) (
    input  logic        mclk,
    input  logic        rstn,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_oe,
    input  logic [31:0] resp_status,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    output logic        crc_err,
    output logic        frame_err
);

    localparam int RX_BITS     = FRAME_LEN - 1;
    localparam int RX_CRC_BITS = CRC_LEN - 1;

    state_t      state_reg, state_next;
    logic [5:0]  rx_cnt_reg;
    logic [45:0] rx_shift_reg;
    logic [5:0]  tx_cnt_reg;
    logic [39:0] tx_shift_reg;
    logic [6:0]  wait_cnt_reg;
    logic        cmd_valid_reg, crc_err_reg, frame_err_reg;
    logic [5:0]  cmd_index_reg;
    logic [31:0] cmd_argument_reg, status_reg;

    logic [6:0]  crc_rx, crc_tx;
    logic [46:0] rx_frame;
    logic        rx_last, frame_ok, crc_ok, tx_bit;

    // The end bit is still on cmd_i when the frame is judged, so the verdict lands in CHECK.
    assign rx_frame = {rx_shift_reg, cmd_i};
    assign rx_last  = (state_reg == RX) && (rx_cnt_reg == 6'(RX_BITS - 1));
    assign frame_ok = rx_frame[46] && rx_frame[0];

`ifdef EMMC_RESP_CRC_CHECK_EN
    assign crc_ok  = (rx_frame[7:1] == crc_rx);
    assign crc_err = crc_err_reg;
`else
    logic unused_rx_crc;
    assign crc_ok        = 1'b1;
    assign crc_err       = 1'b0;
    assign unused_rx_crc = ^{crc_rx, rx_frame[7:1], crc_err_reg};
`endif

    // Start bit is excluded: a zero bit leaves a zero-initialised CRC unchanged.
    emmc_crc7 u_crc_rx (
        .mclk (mclk),
        .rstn (rstn),
        .clr  (state_reg != RX),
        .en   ((state_reg == RX) && (rx_cnt_reg < 6'(RX_CRC_BITS))),
        .din  (cmd_i),
        .crc  (crc_rx)
    );

    emmc_crc7 u_crc_tx (
        .mclk (mclk),
        .rstn (rstn),
        .clr  (state_reg != TX),
        .en   ((state_reg == TX) && (tx_cnt_reg < 6'(CRC_LEN))),
        .din  (tx_bit),
        .crc  (crc_tx)
    );

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_oe     = 1'b0;
        cmd_o      = 1'b1;
        // Bits 40..46 of the response map tx_cnt[2:0]=0..6 onto CRC bits 6..0.
        if (tx_cnt_reg < 6'(CRC_LEN)) begin
            tx_bit = tx_shift_reg[39];
        end else if (tx_cnt_reg < 6'(FRAME_LEN - 1)) begin
            tx_bit = crc_tx[3'd6 - tx_cnt_reg[2:0]];
        end else begin
            tx_bit = 1'b1;
        end
        case (state_reg)
            IDLE: begin
                if (!cmd_i) state_next = RX;
            end
            RX: begin
                if (rx_last) state_next = CHECK;
            end
            CHECK: begin
                if (!cmd_valid_reg || (cmd_index_reg == CMD0_INDEX)) state_next = IDLE;
                else                                                 state_next = WAIT_NCR;
            end
            WAIT_NCR: begin
                if (wait_cnt_reg == 7'(NCR - 1)) state_next = TX;
            end
            TX: begin
                cmd_oe = 1'b1;
                cmd_o  = tx_bit;
                if (tx_cnt_reg == 6'(FRAME_LEN - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            rx_cnt_reg       <= '0;
            rx_shift_reg     <= '0;
            tx_cnt_reg       <= '0;
            tx_shift_reg     <= '0;
            wait_cnt_reg     <= '0;
            cmd_valid_reg    <= 1'b0;
            crc_err_reg      <= 1'b0;
            frame_err_reg    <= 1'b0;
            cmd_index_reg    <= '0;
            cmd_argument_reg <= '0;
            status_reg       <= '0;
        end else begin
            cmd_valid_reg <= 1'b0;
            crc_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: rx_cnt_reg <= '0;
                RX: begin
                    rx_shift_reg <= {rx_shift_reg[44:0], cmd_i};
                    rx_cnt_reg   <= rx_cnt_reg + 6'd1;
                    if (rx_last) begin
                        frame_err_reg <= !frame_ok;
                        crc_err_reg   <= frame_ok && !crc_ok;
                        if (frame_ok && crc_ok) begin
                            cmd_valid_reg    <= 1'b1;
                            cmd_index_reg    <= rx_frame[45:40];
                            cmd_argument_reg <= rx_frame[39:8];
                            status_reg       <= resp_status;
                        end
                    end
                end
                CHECK: begin
                    wait_cnt_reg <= '0;
                    tx_cnt_reg   <= '0;
                    tx_shift_reg <= {2'b00, cmd_index_reg, status_reg};
                end
                WAIT_NCR: wait_cnt_reg <= wait_cnt_reg + 7'd1;
                TX: begin
                    tx_cnt_reg   <= tx_cnt_reg + 6'd1;
                    tx_shift_reg <= {tx_shift_reg[38:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign cmd_valid    = cmd_valid_reg;
    assign frame_err    = frame_err_reg;
    assign cmd_index    = cmd_index_reg;
    assign cmd_argument = cmd_argument_reg;

endmodule
